// File: rtl/sobel_edge_stream.sv
// Streaming 3x3 Sobel edge detector: two line buffers build the window, a two-stage
// gradient pipeline sits behind valid/ready on both sides, and a frame FSM wraps it.
module sobel_edge_stream #(
    parameter int PIX_W    = 8,
    parameter int OUT_W    = 16,
    parameter int IMG_W    = 640,
    parameter int IMG_H    = 480,
    parameter int EDGE_VAL = 255
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_start,
    input  logic             i_mode,
    input  logic [OUT_W-1:0] i_threshold,
    input  logic             i_in_valid,
    output logic             o_in_ready,
    input  logic [PIX_W-1:0] i_in_pixel,
    output logic             o_out_valid,
    input  logic             i_out_ready,
    output logic [OUT_W-1:0] o_out_dx,
    output logic             o_out_dx_sign,
    output logic [OUT_W-1:0] o_out_dy,
    output logic             o_out_dy_sign,
    output logic [OUT_W-1:0] o_out_mag,
    output logic             o_out_edge,
    output logic             o_out_sof,
    output logic             o_out_eol,
    output logic             o_busy,
    output logic             o_frame_done
);
    localparam int SW = PIX_W + 3;
    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);

    if (OUT_W < PIX_W + 3) begin : g_bad_out_w
        $error("sobel_edge_stream: OUT_W must be >= PIX_W+3");
    end
    if (IMG_W < 3 || IMG_H < 3) begin : g_bad_img
        $error("sobel_edge_stream: IMG_W and IMG_H must be >= 3");
    end

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t            r_state, w_next;
    logic              r_mode;
    logic [OUT_W-1:0]  r_thr;
    logic [CW-1:0]     r_col;
    logic [RW-1:0]     r_row;
    logic [PIX_W-1:0]  r_lb0 [IMG_W];
    logic [PIX_W-1:0]  r_lb1 [IMG_W];
    logic [PIX_W-1:0]  r_win [3][3];
    logic              r_v0, r_sof0, r_eol0;
    logic              r_v1, r_sof1, r_eol1;
    logic [SW-1:0]     r_l, r_r, r_t, r_b;

    logic              w_stall, w_accept, w_last, w_emit, w_empty;
    logic [SW-1:0]     w_l, w_r, w_t, w_b, w_dx, w_dy;
    logic              w_dx_sign, w_dy_sign, w_edge;
    logic [OUT_W-1:0]  w_mag, w_mag_out;

    assign w_stall    = o_out_valid & ~i_out_ready;
    assign o_in_ready = (r_state == S_RUN) & ~w_stall;
    assign w_accept   = i_in_valid & o_in_ready;
    assign w_last     = (r_row == RW'(IMG_H - 1)) && (r_col == CW'(IMG_W - 1));
    assign w_emit     = (r_row >= RW'(2)) && (r_col >= CW'(2));
    assign w_empty    = ~r_v0 & ~r_v1 & ~o_out_valid;
    assign o_busy       = (r_state != S_IDLE);
    assign o_frame_done = (r_state == S_DONE);

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (i_start) w_next = S_RUN;
            S_RUN:   if (w_accept && w_last) w_next = S_DRAIN;
            S_DRAIN: if (w_empty) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Line buffers hold the two previous rows; the window shifts one column per accepted pixel.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_lb1[r_col] <= r_lb0[r_col];
            r_lb0[r_col] <= i_in_pixel;
            for (int r = 0; r < 3; r++) begin
                r_win[r][0] <= r_win[r][1];
                r_win[r][1] <= r_win[r][2];
            end
            r_win[0][2] <= r_lb1[r_col];
            r_win[1][2] <= r_lb0[r_col];
            r_win[2][2] <= i_in_pixel;
        end
    end

    assign w_l = SW'(r_win[0][0]) + (SW'(r_win[1][0]) << 1) + SW'(r_win[2][0]);
    assign w_r = SW'(r_win[0][2]) + (SW'(r_win[1][2]) << 1) + SW'(r_win[2][2]);
    assign w_t = SW'(r_win[0][0]) + (SW'(r_win[0][1]) << 1) + SW'(r_win[0][2]);
    assign w_b = SW'(r_win[2][0]) + (SW'(r_win[2][1]) << 1) + SW'(r_win[2][2]);

    assign w_dx_sign = (r_l > r_r);
    assign w_dy_sign = (r_t > r_b);
    assign w_dx      = w_dx_sign ? (r_l - r_r) : (r_r - r_l);
    assign w_dy      = w_dy_sign ? (r_t - r_b) : (r_b - r_t);
    assign w_mag     = OUT_W'(w_dx) + OUT_W'(w_dy);
    assign w_edge    = (w_mag >= r_thr);
    assign w_mag_out = r_mode ? (w_edge ? OUT_W'(EDGE_VAL) : '0) : w_mag;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_mode        <= 1'b0;
            r_thr         <= '0;
            r_col         <= '0;
            r_row         <= '0;
            r_v0          <= 1'b0;
            r_sof0        <= 1'b0;
            r_eol0        <= 1'b0;
            r_v1          <= 1'b0;
            r_sof1        <= 1'b0;
            r_eol1        <= 1'b0;
            r_l           <= '0;
            r_r           <= '0;
            r_t           <= '0;
            r_b           <= '0;
            o_out_valid   <= 1'b0;
            o_out_dx      <= '0;
            o_out_dx_sign <= 1'b0;
            o_out_dy      <= '0;
            o_out_dy_sign <= 1'b0;
            o_out_mag     <= '0;
            o_out_edge    <= 1'b0;
            o_out_sof     <= 1'b0;
            o_out_eol     <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == S_IDLE && i_start) begin
                r_mode <= i_mode;
                r_thr  <= i_threshold;
                r_col  <= '0;
                r_row  <= '0;
            end else if (w_accept) begin
                if (r_col == CW'(IMG_W - 1)) begin
                    r_col <= '0;
                    r_row <= r_row + 1'b1;
                end else begin
                    r_col <= r_col + 1'b1;
                end
            end
            // A stall freezes every stage; data registers only load behind a valid beat.
            if (!w_stall) begin
                r_v0   <= w_accept & w_emit;
                r_sof0 <= (r_row == RW'(2)) && (r_col == CW'(2));
                r_eol0 <= (r_col == CW'(IMG_W - 1));
                r_v1   <= r_v0;
                r_sof1 <= r_sof0;
                r_eol1 <= r_eol0;
                if (r_v0) begin
                    r_l <= w_l;
                    r_r <= w_r;
                    r_t <= w_t;
                    r_b <= w_b;
                end
                o_out_valid <= r_v1;
                o_out_sof   <= r_v1 & r_sof1;
                o_out_eol   <= r_v1 & r_eol1;
                if (r_v1) begin
                    o_out_dx      <= OUT_W'(w_dx);
                    o_out_dx_sign <= w_dx_sign;
                    o_out_dy      <= OUT_W'(w_dy);
                    o_out_dy_sign <= w_dy_sign;
                    o_out_mag     <= w_mag_out;
                    o_out_edge    <= w_edge;
                end
            end
        end
    end
endmodule

// File: tb/tb_sobel_edge_stream.sv
// Self-checking bench for sobel_edge_stream on an 8x6 frame: directed images plus
// random images, compared against a direct Sobel model of the whole frame.
module tb_sobel_edge_stream;
    localparam int W     = 8;
    localparam int H     = 6;
    localparam int NPIX  = W * H;
    localparam int LIMIT = 3000;

    logic        clk;
    logic        rst_n;
    logic        i_start, i_mode, i_in_valid, i_out_ready;
    logic [15:0] i_threshold;
    logic [7:0]  i_in_pixel;
    logic        o_in_ready, o_out_valid, o_out_dx_sign, o_out_dy_sign;
    logic [15:0] o_out_dx, o_out_dy, o_out_mag;
    logic        o_out_edge, o_out_sof, o_out_eol, o_busy, o_frame_done;

    sobel_edge_stream #(
        .PIX_W(8), .OUT_W(16), .IMG_W(W), .IMG_H(H), .EDGE_VAL(255)
    ) dut (
        .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_mode(i_mode),
        .i_threshold(i_threshold), .i_in_valid(i_in_valid), .o_in_ready(o_in_ready),
        .i_in_pixel(i_in_pixel), .o_out_valid(o_out_valid), .i_out_ready(i_out_ready),
        .o_out_dx(o_out_dx), .o_out_dx_sign(o_out_dx_sign), .o_out_dy(o_out_dy),
        .o_out_dy_sign(o_out_dy_sign), .o_out_mag(o_out_mag), .o_out_edge(o_out_edge),
        .o_out_sof(o_out_sof), .o_out_eol(o_out_eol), .o_busy(o_busy),
        .o_frame_done(o_frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          img [H][W];
    logic [52:0] expQ [$];
    logic [52:0] gotQ [$];
    int          checks, failures;
    int          doneCount, beatsAtDone, acceptEdge22, firstValidEdge;
    bit          timedOut;

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [52:0] dutBeat();
        return {o_out_dx, o_out_dx_sign, o_out_dy, o_out_dy_sign, o_out_mag,
                o_out_edge, o_out_sof, o_out_eol};
    endfunction

    // Reference: Sobel sums on every interior centre of the stored image, raster order.
    function automatic void buildExpected(input bit modeIn, input int thr);
        int l, rr, t, b, dx, dy, mag, om;
        bit edg;
        expQ.delete();
        for (int r = 1; r <= H - 2; r++) begin
            for (int c = 1; c <= W - 2; c++) begin
                l  = img[r-1][c-1] + 2 * img[r][c-1] + img[r+1][c-1];
                rr = img[r-1][c+1] + 2 * img[r][c+1] + img[r+1][c+1];
                t  = img[r-1][c-1] + 2 * img[r-1][c] + img[r-1][c+1];
                b  = img[r+1][c-1] + 2 * img[r+1][c] + img[r+1][c+1];
                dx  = (l > rr) ? l - rr : rr - l;
                dy  = (t > b) ? t - b : b - t;
                mag = dx + dy;
                edg = (mag >= thr);
                om  = modeIn ? (edg ? 255 : 0) : mag;
                expQ.push_back({16'(dx), l > rr, 16'(dy), t > b, 16'(om), edg,
                                (r == 1 && c == 1), (c == W - 2)});
            end
        end
    endfunction

    function automatic void fillFlat(input int v);
        for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) img[r][c] = v;
    endfunction

    function automatic void fillVStep();
        for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) img[r][c] = (c >= 4) ? 100 : 0;
    endfunction

    function automatic void fillHStep();
        for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) img[r][c] = (r >= 3) ? 10 : 50;
    endfunction

    function automatic void fillRandom();
        for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) img[r][c] = int'($urandom_range(0, 255));
    endfunction

    // Pulses start, streams img, collects accepted beats; stops early after abortAfter pixels if >= 0.
    task automatic applyStimulus(input bit modeIn, input logic [15:0] thrIn, input bit randIn,
                                 input bit randOut, input int abortAfter);
        int idx, cyc, postDone;
        bit acc, stalledPrev;
        logic [52:0] held, cur;
        gotQ.delete();
        doneCount = 0; beatsAtDone = -1; acceptEdge22 = -1; firstValidEdge = -1; timedOut = 1'b0;
        i_in_valid = 1'b0; i_mode = modeIn; i_threshold = thrIn; i_start = 1'b1;
        @(posedge clk); #1;
        i_start = 1'b0; i_mode = ~modeIn; i_threshold = ~thrIn;
        idx = 0; cyc = 0; postDone = 0; stalledPrev = 1'b0; held = '0;
        while (1) begin
            if (cyc >= LIMIT) begin
                timedOut = 1'b1;
                break;
            end
            i_in_valid  = (idx < NPIX) && (!randIn || $urandom_range(0, 1) == 1);
            i_in_pixel  = (idx < NPIX) ? 8'(img[idx / W][idx % W]) : 8'($urandom);
            i_out_ready = !randOut || $urandom_range(0, 1) == 1;
            @(negedge clk);
            cur = dutBeat();
            if (stalledPrev) checkOutput("stall_hold", 64'(cur), 64'(held));
            if (o_frame_done) begin
                if (doneCount == 0) beatsAtDone = gotQ.size();
                doneCount++;
            end
            acc = i_in_valid && o_in_ready;
            if (acc && idx == 2 * W + 2) acceptEdge22 = cyc + 1;
            if (o_out_valid && firstValidEdge < 0) firstValidEdge = cyc;
            if (o_out_valid && i_out_ready) gotQ.push_back(cur);
            stalledPrev = o_out_valid && !i_out_ready;
            held = cur;
            @(posedge clk); #1;
            cyc++;
            if (acc) idx++;
            if (abortAfter >= 0 && idx >= abortAfter) break;
            if (doneCount > 0) postDone++;
            if (postDone > 4) break;
        end
        i_in_valid = 1'b0;
    endtask

    task automatic checkFrame(input string tag);
        checkOutput({tag, "_timeout"}, 64'(timedOut), 64'(0));
        checkOutput({tag, "_beat_count"}, 64'(gotQ.size()), 64'(expQ.size()));
        for (int i = 0; i < expQ.size() && i < gotQ.size(); i++)
            checkOutput($sformatf("%s_beat%0d", tag, i), 64'(gotQ[i]), 64'(expQ[i]));
        checkOutput({tag, "_frame_done_count"}, 64'(doneCount), 64'(1));
        checkOutput({tag, "_done_after_last"}, 64'(beatsAtDone), 64'(expQ.size()));
    endtask

    initial begin
        int  idleDone;
        bit  m;
        int  thr;
        checks = 0; failures = 0;
        rst_n = 1'b0; i_start = 1'b0; i_mode = 1'b0; i_threshold = '0;
        i_in_valid = 1'b0; i_in_pixel = '0; i_out_ready = 1'b0;
        #12;
        checkOutput("reset_outputs", 64'({dutBeat(), o_out_valid, o_in_ready, o_busy, o_frame_done}), 64'(0));
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        checkOutput("idle_after_reset", 64'({o_busy, o_in_ready}), 64'(0));

        fillFlat(77); buildExpected(1'b0, 1);
        applyStimulus(1'b0, 16'd1, 1'b0, 1'b0, -1);
        checkFrame("flat");

        fillVStep(); buildExpected(1'b0, 255);
        applyStimulus(1'b0, 16'd255, 1'b0, 1'b0, -1);
        checkFrame("vstep");
        checkOutput("latency", 64'(firstValidEdge - acceptEdge22), 64'(2));
        checkOutput("vstep_spot", (gotQ.size() > 2) ? 64'(gotQ[2]) : '1,
                    64'({16'd400, 1'b0, 16'd0, 1'b0, 16'd400, 1'b1, 1'b0, 1'b0}));

        fillHStep(); buildExpected(1'b1, 160);
        applyStimulus(1'b1, 16'd160, 1'b0, 1'b0, -1);
        checkFrame("hstep160");
        checkOutput("hstep_spot", (gotQ.size() > 7) ? 64'(gotQ[7]) : '1,
                    64'({16'd0, 1'b0, 16'd160, 1'b1, 16'd255, 1'b1, 1'b0, 1'b0}));

        buildExpected(1'b1, 161);
        applyStimulus(1'b1, 16'd161, 1'b0, 1'b0, -1);
        checkFrame("hstep161");

        fillVStep(); buildExpected(1'b0, 255);
        applyStimulus(1'b0, 16'd255, 1'b1, 1'b1, -1);
        checkFrame("backpressure");

        fillRandom();
        applyStimulus(1'b0, 16'd1, 1'b0, 1'b0, 20);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("abort_cleared", 64'({dutBeat(), o_out_valid, o_in_ready, o_busy, o_frame_done}), 64'(0));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        idleDone = 0;
        repeat (10) begin
            @(negedge clk);
            if (o_frame_done || o_busy) idleDone++;
        end
        checkOutput("abort_no_done", 64'(idleDone), 64'(0));
        @(posedge clk); #1;
        fillFlat(77); buildExpected(1'b0, 1);
        applyStimulus(1'b0, 16'd1, 1'b0, 1'b0, -1);
        checkFrame("after_abort");

        for (int k = 0; k < 3; k++) begin
            fillRandom();
            m   = ($urandom_range(0, 1) == 1);
            thr = int'($urandom_range(0, 1200));
            buildExpected(m, thr);
            applyStimulus(m, 16'(thr), $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, -1);
            checkFrame($sformatf("random%0d", k));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/sobel_edge_stream.md
Name: sobel_edge_stream

Overview:
Streaming 3x3 Sobel edge detector for raster-scan frames. Two internal line buffers build the 3x3 window, so upstream only supplies one pixel per beat. Valid/ready handshakes on input and output, and a frame-level start/done FSM. It computes |Gx| and |Gy| with sign flags, the L1 magnitude, and a thresholded edge output. Runtime mode selects raw magnitude or binary edge map.

Parameters:
PIX_W, 8, input pixel width (unsigned).
OUT_W, 16, gradient/magnitude output width; must be >= PIX_W+3 (elaboration error otherwise).
IMG_W, 640, pixels per line (>=3); sets line-buffer depth.
IMG_H, 480, lines per frame (>=3).
EDGE_VAL, 255, value driven on out_mag for an edge pixel in binary mode.

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  asynchronous, active-low reset
start  in  1  one-cycle pulse: begin a frame (honoured only in IDLE)
mode  in  1  0 = magnitude output, 1 = binary edge output; sampled on accepted start
threshold  in  OUT_W  edge threshold; sampled on accepted start
in_valid  in  1  in_pixel valid
in_ready  out  1  block accepts in_pixel this cycle
in_pixel  in  PIX_W  raster-order pixel
out_valid  out  1  output beat valid
out_ready  in  1  downstream accepts beat
out_dx  out  OUT_W  |Gx|
out_dx_sign  out  1  1 when left column sum > right column sum
out_dy  out  OUT_W  |Gy|
out_dy_sign  out  1  1 when top row sum > bottom row sum
out_mag  out  OUT_W  mode0: |Gx|+|Gy|; mode1: EDGE_VAL if edge else 0
out_edge  out  1  (|Gx|+|Gy|) >= threshold
out_sof  out  1  first output beat of frame
out_eol  out  1  last output beat of each output row
busy  out  1  FSM not IDLE
frame_done  out  1  one-cycle pulse at end of frame

Behaviour:
- Reset (async, reset low): FSM=IDLE; counters, pipeline valids, all outputs 0; in_ready=0. Line-buffer contents need not clear; the write pointer restarts at 0.
- FSM states:
  - IDLE: start=1 latches mode/threshold, clears row/col counters, goes to RUN.
  - RUN: in_ready = !stall, where stall = out_valid & !out_ready. After the pixel at (IMG_H-1, IMG_W-1) is accepted, go to DRAIN.
  - DRAIN: in_ready=0; when the pipeline is empty, go to DONE.
  - DONE: frame_done=1 for one cycle, then IDLE.
  - start outside IDLE is ignored.
- Window: w[r][c], r=0 top, c=0 left. Output is produced only for interior centres. Accepting pixel (row,col) with row>=2 and col>=2 emits the window centred at (row-1,col-1). There are exactly (IMG_W-2)*(IMG_H-2) beats per frame.
- Arithmetic (unsigned, at least PIX_W+3 bits internally):
  - L = w00+2w10+w20, R = w02+2w12+w22; out_dx = |L-R|, out_dx_sign = L>R.
  - T = w00+2w01+w02, B = w20+2w21+w22; out_dy = |T-B|, out_dy_sign = T>B.
  - Equal sums give 0 with sign 0.
  - Magnitude never overflows given the OUT_W constraint.
- Pipeline: two stages (window+sums, then abs/mag/threshold). out_valid rises 2 cycles after the accepting edge when not stalled.
- Stall freezes every stage; output data is held stable while out_valid & !out_ready.
- out_sof is asserted on the beat centred at (1,1). out_eol is asserted on centres with col = IMG_W-2.
- Line buffers write on every accepted pixel; col wraps at IMG_W-1 and row increments.
- Simultaneous in handshake and out handshake is legal; full throughput is 1 pixel/cycle.
- Reset mid-frame aborts immediately. No frame_done is issued, and the next frame needs a fresh start.
- mode/threshold changes mid-frame have no effect until the next start.

Test Plan:
1. Config IMG_W=8, IMG_H=6. Flat image of all 77, mode0 -> 24 beats, all dx=dy=mag=0, edge=0 at threshold 1, sof on beat 0, eol on beats 5/11/17/23, one frame_done.
2. Vertical step: cols 0-3=0, cols 4-7=100 -> centre cols 3 and 4 give dx=400, dx_sign=0, dy=0, mag=400, edge=1 at threshold 255; all other centres give 0.
3. Horizontal step: rows 0-2=50, rows 3-5=10, mode1, EDGE_VAL=255:
   - threshold 160: centre rows 2,3 give dy=160, dy_sign=1, out_mag=255, edge=1.
   - threshold 161: same centres give out_mag=0, edge=0.
4. Backpressure: random out_ready (~50%) with random in_valid on the step image -> output sequence identical to case 2, no drops or duplicates, data stable while stalled.
5. Latency: continuous in_valid, out_ready=1 -> first out_valid exactly 2 cycles after acceptance of pixel (2,2); frame_done follows the last beat once DRAIN empties.
6. Reset mid-frame after 20 pixels, then start a new flat frame -> outputs cleared immediately, no frame_done, second frame produces exactly 24 correct beats.
